// File: rtl/w5500_slv_pkg.sv
// Shared types and constants for the W5500 SPI responder: FSM states,
// operation-mode encodings and the fixed-length byte-count lookup.
package w5500_slv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        CTRL,
        DATA,
        DONE
    } state_t;

    localparam logic [1:0] OM_VDM  = 2'b00;
    localparam logic [1:0] OM_FDM1 = 2'b01;
    localparam logic [1:0] OM_FDM2 = 2'b10;
    localparam logic [1:0] OM_FDM4 = 2'b11;

    localparam logic RWB_WRITE = 1'b1;

    // Variable-length mode has no byte limit and reports 0.
    function automatic logic [2:0] om_byte_count(input logic [1:0] om);
        case (om)
            OM_FDM1: return 3'd1;
            OM_FDM2: return 3'd2;
            OM_FDM4: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_slv_sync_edge.sv
// Multi-flop synchronizer for one SPI pin with rise/fall detection
// taken from the last two synchronized samples.
module spi_slv_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Resetting to 0 means a CS held low across reset never looks like a
    // falling edge, so the slave waits for a clean new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/w5500_spi_slave.sv
// W5500 host-interface SPI responder (mode 0, MSB first) for simulation and
// loop-back. Define W5500_SLV_ERR_EN to add the o_err framing-error pulse.
module w5500_spi_slave
    import w5500_slv_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_MISO   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_cs,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [15:0] o_addr,
    output logic [4:0]  o_bsb,
    output logic        o_wr_en,
    output logic [7:0]  o_wr_dat,
    output logic        o_rd_req,
    input  logic [7:0]  i_rd_dat,
    output logic        o_frame_end
`ifdef W5500_SLV_ERR_EN
    ,
    output logic        o_err
`endif
);

    logic cs_rise, cs_fall, sck_rise, sck_fall, mosi_s;

    spi_slv_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
        .clk(clk), .rst_n(rst_n), .din(spi_cs),
        .dout(), .rise(cs_rise), .fall(cs_fall)
    );

    spi_slv_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
        .clk(clk), .rst_n(rst_n), .din(spi_sck),
        .dout(), .rise(sck_rise), .fall(sck_fall)
    );

    spi_slv_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
        .clk(clk), .rst_n(rst_n), .din(spi_mosi),
        .dout(mosi_s), .rise(), .fall()
    );

    state_t      state_q, state_nxt;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  shift_q;
    logic [7:0]  rx_byte;
    logic        rwb_q;
    logic [1:0]  om_q;
    logic [2:0]  byte_cnt_q;
    logic        wr_pend_q;
    logic        rd_load_q;
    logic [7:0]  tx_q;
    logic        miso_q;

    logic        shift_en, byte_done, tx_en, frame_end_set;
`ifdef W5500_SLV_ERR_EN
    logic        err_set;
`endif

    assign rx_byte = {shift_q, mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // A CS rise outranks everything else, including a coincident 8th SCK rise.
    always_comb begin
        state_nxt     = state_q;
        shift_en      = 1'b0;
        byte_done     = 1'b0;
        tx_en         = 1'b0;
        frame_end_set = 1'b0;
`ifdef W5500_SLV_ERR_EN
        err_set       = 1'b0;
`endif
        if (state_q != IDLE && cs_rise) begin
            state_nxt     = IDLE;
            frame_end_set = 1'b1;
`ifdef W5500_SLV_ERR_EN
            err_set       = (bit_cnt_q != 3'd0);
`endif
        end else begin
            case (state_q)
                IDLE: if (cs_fall) state_nxt = ADDR_HI;
                ADDR_HI, ADDR_LO, CTRL, DATA: begin
                    shift_en  = sck_rise;
                    byte_done = sck_rise && (bit_cnt_q == 3'd7);
                    tx_en     = sck_fall && (state_q == DATA) && (rwb_q != RWB_WRITE);
                    if (byte_done) begin
                        case (state_q)
                            ADDR_HI: state_nxt = ADDR_LO;
                            ADDR_LO: state_nxt = CTRL;
                            CTRL:    state_nxt = DATA;
                            default: begin
                                if (om_q != OM_VDM &&
                                    (byte_cnt_q + 3'd1) == om_byte_count(om_q))
                                    state_nxt = DONE;
                            end
                        endcase
                    end
                end
                DONE: begin
`ifdef W5500_SLV_ERR_EN
                    err_set = sck_rise;
`endif
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Writes strobe one cycle after the data byte lands and bump the address
    // afterwards; reads bump first so o_rd_req always names the next byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            o_addr      <= '0;
            o_bsb       <= '0;
            rwb_q       <= 1'b0;
            om_q        <= '0;
            byte_cnt_q  <= '0;
            o_wr_dat    <= '0;
            o_wr_en     <= 1'b0;
            wr_pend_q   <= 1'b0;
            o_rd_req    <= 1'b0;
            rd_load_q   <= 1'b0;
            tx_q        <= '0;
            miso_q      <= IDLE_MISO;
            o_frame_end <= 1'b0;
        end else begin
            o_frame_end <= frame_end_set;
            o_wr_en     <= wr_pend_q;
            wr_pend_q   <= 1'b0;
            o_rd_req    <= 1'b0;
            rd_load_q   <= o_rd_req;

            if (state_q == IDLE || frame_end_set) begin
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                shift_q   <= rx_byte[6:0];
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            if (o_wr_en) o_addr <= o_addr + 16'd1;

            if (byte_done) begin
                case (state_q)
                    ADDR_HI: o_addr[15:8] <= rx_byte;
                    ADDR_LO: o_addr[7:0]  <= rx_byte;
                    CTRL: begin
                        o_bsb      <= rx_byte[7:3];
                        rwb_q      <= rx_byte[2];
                        om_q       <= rx_byte[1:0];
                        byte_cnt_q <= '0;
                        miso_q     <= IDLE_MISO;
                        if (rx_byte[2] != RWB_WRITE) o_rd_req <= 1'b1;
                    end
                    DATA: begin
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                        if (rwb_q == RWB_WRITE) begin
                            o_wr_dat  <= rx_byte;
                            wr_pend_q <= 1'b1;
                        end else begin
                            o_addr <= o_addr + 16'd1;
                            if (state_nxt == DATA) o_rd_req <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (rd_load_q) begin
                tx_q <= i_rd_dat;
            end else if (tx_en) begin
                miso_q <= tx_q[7];
                tx_q   <= {tx_q[6:0], 1'b0};
            end
        end
    end

`ifdef W5500_SLV_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_err <= 1'b0;
        else        o_err <= err_set;
    end
`endif

    assign spi_miso = (state_q == DATA && rwb_q != RWB_WRITE) ? miso_q : IDLE_MISO;

endmodule
